// File: rtl/acq_capture_ctrl.sv
`default_nettype none
// ============================================================================
// acq_capture_ctrl : captures ADC samples into a PSRAM ring buffer around a
//                    threshold/button trigger, then streams the window to UART
// Rev 1.0
// ============================================================================
module acq_capture_ctrl #(
  parameter int ADDR_W   = 22,
  parameter int SAMPLE_W = 12
) (
  input  logic                clk_PSRAM,
  input  logic                rst,
  input  logic                flag_acq,
  input  logic [7:0]          trigger,
  input  logic [12:0]         threshold,
  input  logic [21:0]         samples_before,
  input  logic [21:0]         samples_after,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  input  logic                btn_trig,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_wdata,
  input  logic                mem_ack,
  input  logic [15:0]         mem_rdata,
  output logic                send_uart,
  output logic [15:0]         send_msg,
  input  logic                flag_end_tx,
  output logic                acq_busy,
  output logic                triggered,
  output logic                overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_ARMED  = 3'd2,
    S_POST   = 3'd3,
    S_READ   = 3'd4,
    S_TXWAIT = 3'd5
  } state_t;

  state_t              state;
  logic                cfg_btn;
  logic [12:0]         cfg_thr;
  logic [21:0]         cfg_before;
  logic [21:0]         cfg_after;
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   rptr;
  logic [ADDR_W-1:0]   trig_addr;
  logic [21:0]         wr_cnt;
  logic [22:0]         remaining;
  logic [SAMPLE_W-1:0] prev;
  logic                btn_prev;
  logic                btn_latch;
  logic                guard;

  logic                cap_state;
  logic                accept;
  logic                thr_hit;
  logic                trig_fire;
  logic [21:0]         wr_cnt_nx;
  logic [ADDR_W-1:0]   rd_start;
  logic [ADDR_W-1:0]   rptr_nx;

  // A sample is only taken when no write is in flight; otherwise it is lost.
  assign cap_state = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
  assign accept    = cap_state && adc_valid && !mem_req;
  assign thr_hit   = (13'(prev) < cfg_thr) && (13'(adc_data) >= cfg_thr);
  assign trig_fire = (state == S_ARMED) && accept && (cfg_btn ? btn_latch : thr_hit);
  assign wr_cnt_nx = wr_cnt + 22'd1;
  assign rd_start  = trig_addr - ADDR_W'(cfg_before);
  assign rptr_nx   = rptr + ADDR_W'(1);

  always_ff @(posedge clk_PSRAM) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_btn    <= 1'b0;
      cfg_thr    <= '0;
      cfg_before <= '0;
      cfg_after  <= '0;
      wptr       <= '0;
      rptr       <= '0;
      trig_addr  <= '0;
      wr_cnt     <= '0;
      remaining  <= '0;
      prev       <= '0;
      btn_prev   <= 1'b0;
      btn_latch  <= 1'b0;
      guard      <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      send_uart  <= 1'b0;
      send_msg   <= '0;
      acq_busy   <= 1'b0;
      triggered  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      send_uart <= 1'b0;
      btn_prev  <= btn_trig;
      if (state == S_ARMED && btn_trig && !btn_prev)
        btn_latch <= 1'b1;
      if (cap_state && adc_valid && mem_req)
        overflow <= 1'b1;

      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wptr;
        mem_wdata <= 16'(adc_data);
        wptr      <= wptr + ADDR_W'(1);
        prev      <= adc_data;
      end

      case (state)
        S_IDLE: begin
          if (flag_acq) begin
            cfg_btn    <= (trigger == 8'h42);
            cfg_thr    <= threshold;
            cfg_before <= samples_before;
            cfg_after  <= (samples_after == 22'd0) ? 22'd1 : samples_after;
            wptr       <= '0;
            wr_cnt     <= '0;
            prev       <= '0;
            btn_latch  <= 1'b0;
            triggered  <= 1'b0;
            overflow   <= 1'b0;
            acq_busy   <= 1'b1;
            state      <= (samples_before == 22'd0) ? S_ARMED : S_FILL;
          end
        end
        S_FILL: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            if (wr_cnt_nx == cfg_before) begin
              wr_cnt <= '0;
              state  <= S_ARMED;
            end else begin
              wr_cnt <= wr_cnt_nx;
            end
          end
        end
        S_ARMED: begin
          if (mem_req && mem_ack)
            mem_req <= 1'b0;
          if (trig_fire) begin
            trig_addr <= wptr;
            triggered <= 1'b1;
            state     <= S_POST;
          end
        end
        S_POST: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            wr_cnt  <= wr_cnt_nx;
            // The trigger sample counts as post-sample #1; read starts right away.
            if (wr_cnt_nx == cfg_after) begin
              rptr      <= rd_start;
              remaining <= {1'b0, cfg_before} + {1'b0, cfg_after};
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= rd_start;
              state     <= S_READ;
            end
          end
        end
        S_READ: begin
          if (mem_req && mem_ack) begin
            mem_req   <= 1'b0;
            send_msg  <= mem_rdata;
            send_uart <= 1'b1;
            guard     <= 1'b1;
            state     <= S_TXWAIT;
          end
        end
        S_TXWAIT: begin
          // flag_end_tx may still show the previous idle level during the pulse and the cycle after.
          if (send_uart) begin
            guard <= 1'b1;
          end else if (guard) begin
            guard <= 1'b0;
          end else if (flag_end_tx) begin
            rptr      <= rptr_nx;
            remaining <= remaining - 23'd1;
            if (remaining == 23'd1) begin
              acq_busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= rptr_nx;
              state    <= S_READ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
